// File: rtl/stopwatch_pkg.sv
// Shared defaults, state encoding and BCD helpers for the countdown timer.
package stopwatch_pkg;

    localparam int unsigned DEF_PULSES_PER_SECOND = 100;
    localparam int unsigned DEF_THRESHOLD         = 5;
    localparam int unsigned DEF_ALARM_TICKS       = 300;

    localparam logic [23:0] PRESET_RESET = 24'h010000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        ALARM
    } state_t;

    // Subtract 0.01 s; digit limits per position are 9,9,9,5,9,5.
    function automatic logic [23:0] bcd_dec(input logic [23:0] d);
        logic [23:0] r;
        logic        borrow;
        r      = d;
        borrow = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (borrow) begin
                if (d[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = (i == 3 || i == 5) ? 4'd5 : 4'd9;
                end else begin
                    r[i*4 +: 4] = d[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/countdown_timer_key_press.sv
// Key synchronizer plus hold-time classifier producing one-clk short/long events.
import stopwatch_pkg::*;

module key_press #(
    parameter int unsigned PULSES_PER_SECOND = DEF_PULSES_PER_SECOND,
    parameter int unsigned THRESHOLD         = DEF_THRESHOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key,
    output logic short_press,
    output logic long_press
);

    localparam int unsigned CW = $clog2(PULSES_PER_SECOND + 1);
    localparam logic [CW-1:0] PPS_C = CW'(PULSES_PER_SECOND);
    localparam logic [CW-1:0] THR_C = CW'(THRESHOLD);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          pressed;

    assign pressed = ~sync[1];

    // Saturation at PPS_C makes the long event single-shot and suppresses the release short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= '1;
            cnt         <= '0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            sync        <= {sync[0], key};
            short_press <= 1'b0;
            long_press  <= 1'b0;
            if (pressed) begin
                if (tick && cnt < PPS_C) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == PPS_C - 1'b1)
                        long_press <= 1'b1;
                end
            end else begin
                if (cnt > THR_C && cnt < PPS_C)
                    short_press <= 1'b1;
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: preset editing in IDLE, BCD countdown in RUN, timed alarm.
import stopwatch_pkg::*;

module countdown_timer #(
    parameter int unsigned PULSES_PER_SECOND = DEF_PULSES_PER_SECOND,
    parameter int unsigned THRESHOLD         = DEF_THRESHOLD,
    parameter int unsigned ALARM_TICKS       = DEF_ALARM_TICKS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        ssr,
    input  logic        sel,
    input  logic        inc,
    output logic [23:0] digits,
    output logic        field,
    output logic        running,
    output logic        alarm
);

    localparam int unsigned AW = $clog2(ALARM_TICKS + 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

    state_t        state, state_nxt;
    logic [23:0]   preset, count, count_dec;
    logic [AW-1:0] acnt;
    logic          ssr_short, ssr_long, sel_short, sel_long, inc_short, inc_long;
    logic          reach_zero;

    key_press #(.PULSES_PER_SECOND(PULSES_PER_SECOND), .THRESHOLD(THRESHOLD)) u_ssr (
        .clk(clk), .rst_n(rst_n), .tick(tick), .key(ssr),
        .short_press(ssr_short), .long_press(ssr_long)
    );
    key_press #(.PULSES_PER_SECOND(PULSES_PER_SECOND), .THRESHOLD(THRESHOLD)) u_sel (
        .clk(clk), .rst_n(rst_n), .tick(tick), .key(sel),
        .short_press(sel_short), .long_press(sel_long)
    );
    key_press #(.PULSES_PER_SECOND(PULSES_PER_SECOND), .THRESHOLD(THRESHOLD)) u_inc (
        .clk(clk), .rst_n(rst_n), .tick(tick), .key(inc),
        .short_press(inc_short), .long_press(inc_long)
    );

    assign count_dec  = bcd_dec(count);
    assign reach_zero = tick && (count != '0) && (count_dec == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Zero-reach outranks a coincident short press; long press outranks both.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (ssr_short && preset != '0) state_nxt = RUN;
            RUN: begin
                if (ssr_long)        state_nxt = IDLE;
                else if (reach_zero) state_nxt = ALARM;
                else if (ssr_short)  state_nxt = PAUSE;
            end
            PAUSE: begin
                if (ssr_long)       state_nxt = IDLE;
                else if (ssr_short) state_nxt = RUN;
            end
            ALARM: begin
                if (ssr_long || ssr_short)        state_nxt = IDLE;
                else if (tick && acnt == ALARM_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running = (state == RUN);
        alarm   = (state == ALARM);
        digits  = (state == IDLE) ? preset : count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset <= PRESET_RESET;
            count  <= PRESET_RESET;
            field  <= 1'b0;
            acnt   <= '0;
        end else begin
            if (state == IDLE) begin
                count <= preset;
                if (sel_short)
                    field <= ~field;
                if (inc_short) begin
                    if (field)
                        preset[23:16] <= bcd_inc60(preset[23:16]);
                    else
                        preset[15:8]  <= bcd_inc60(preset[15:8]);
                end
            end else if (state == RUN && tick && count != '0) begin
                count <= count_dec;
            end

            if (state == ALARM) begin
                if (tick)
                    acnt <= acnt + 1'b1;
            end else begin
                acnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; expectations are queued and checked by a monitor.
module tb_countdown_timer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick  = 1'b0;
    logic        ssr   = 1'b1;
    logic        sel   = 1'b1;
    logic        inc   = 1'b1;
    logic [23:0] digits;
    logic        field, running, alarm;

    countdown_timer #(
        .PULSES_PER_SECOND(100),
        .THRESHOLD(5),
        .ALARM_TICKS(300)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .ssr(ssr), .sel(sel), .inc(inc),
        .digits(digits), .field(field), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [23:0] d;
        logic        f;
        logic        r;
        logic        a;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({digits, field, running, alarm} !== {e.d, e.f, e.r, e.a}) begin
                    fails++;
                    $display("FAIL %s: got digits=%h field=%b running=%b alarm=%b, expected digits=%h field=%b running=%b alarm=%b",
                             e.name, digits, field, running, alarm, e.d, e.f, e.r, e.a);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input string name, input logic [23:0] d,
                              input logic f, input logic r, input logic a);
        exp_t e;
        e.name = name; e.d = d; e.f = f; e.r = r; e.a = a;
        sb.push_back(e);
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin @(posedge clk); #1; tick = 1'b1; end
        @(posedge clk); #1; tick = 1'b0;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: ssr = v;
            1: sel = v;
            default: inc = v;
        endcase
    endtask

    // Hold key k for exactly 'hold' ticks after synchronization, then release.
    task automatic press(input int k, input int hold);
        @(posedge clk); #1; set_key(k, 1'b0);
        idle(3);
        if (hold > 0) ticks(hold);
        @(posedge clk); #1; set_key(k, 1'b1);
        idle(5);
    endtask

    initial begin : stimulus
        idle(2);
        expect_out("reset", 24'h010000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(2);

        press(0, 20);
        expect_out("start", 24'h010000, 1'b0, 1'b1, 1'b0);
        ticks(1);
        expect_out("borrow_chain", 24'h005999, 1'b0, 1'b1, 1'b0);
        ticks(5998);
        expect_out("one_left", 24'h000001, 1'b0, 1'b1, 1'b0);
        ticks(1);
        expect_out("zero_alarm", 24'h000000, 1'b0, 1'b0, 1'b1);
        ticks(299);
        expect_out("alarm_hold", 24'h000000, 1'b0, 1'b0, 1'b1);
        ticks(1);
        expect_out("alarm_end", 24'h010000, 1'b0, 1'b0, 1'b0);

        press(0, 3);
        expect_out("ssr_below_threshold", 24'h010000, 1'b0, 1'b0, 1'b0);

        press(2, 8);
        expect_out("inc_once", 24'h010100, 1'b0, 1'b0, 1'b0);
        repeat (59) press(2, 8);
        expect_out("sec_wrap", 24'h010000, 1'b0, 1'b0, 1'b0);
        press(1, 8);
        expect_out("sel_field", 24'h010000, 1'b1, 1'b0, 1'b0);
        press(2, 8);
        expect_out("min_inc", 24'h020000, 1'b1, 1'b0, 1'b0);

        press(0, 8);
        expect_out("run2", 24'h020000, 1'b1, 1'b1, 1'b0);
        ticks(50);
        expect_out("run50", 24'h015950, 1'b1, 1'b1, 1'b0);
        press(0, 8);
        expect_out("pause", 24'h015942, 1'b1, 1'b0, 1'b0);
        ticks(20);
        expect_out("pause_hold", 24'h015942, 1'b1, 1'b0, 1'b0);
        press(2, 8);
        press(1, 8);
        expect_out("pause_keys_ignored", 24'h015942, 1'b1, 1'b0, 1'b0);
        press(0, 8);
        expect_out("resume", 24'h015942, 1'b1, 1'b1, 1'b0);
        press(0, 150);
        expect_out("long_to_idle", 24'h020000, 1'b1, 1'b0, 1'b0);

        press(0, 8);
        expect_out("run3", 24'h020000, 1'b1, 1'b1, 1'b0);
        ticks(7783);
        expect_out("at_42_17", 24'h004217, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        expect_out("async_reset", 24'h010000, 1'b0, 1'b0, 1'b0);
        idle(1);
        rst_n = 1'b1;
        idle(3);
        expect_out("post_reset", 24'h010000, 1'b0, 1'b0, 1'b0);

        press(1, 8);
        repeat (59) press(2, 8);
        expect_out("min_wrap", 24'h000000, 1'b1, 1'b0, 1'b0);
        press(1, 8);
        press(2, 8);
        expect_out("preset_1s", 24'h000100, 1'b0, 1'b0, 1'b0);
        press(0, 8);
        expect_out("run4", 24'h000100, 1'b0, 1'b1, 1'b0);
        ticks(99);
        expect_out("run4_99", 24'h000001, 1'b0, 1'b1, 1'b0);
        ticks(1);
        expect_out("alarm2", 24'h000000, 1'b0, 1'b0, 1'b1);
        ticks(10);
        press(0, 8);
        expect_out("alarm_short_exit", 24'h000100, 1'b0, 1'b0, 1'b0);

        repeat (59) press(2, 8);
        expect_out("zero_preset", 24'h000000, 1'b0, 1'b0, 1'b0);
        press(0, 8);
        expect_out("zero_no_start", 24'h000000, 1'b0, 1'b0, 1'b0);

        idle(2);
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
